// File: rtl/decode_pkg.sv
// Shared decode definitions for the RV32I fetch-to-execute path.
// Major opcodes, one-hot class bit indices, decoded record type, immediate helper.
package decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int CLS_REG_ARITH = 0;
    localparam int CLS_IMM_ARITH = 1;
    localparam int CLS_LOAD      = 2;
    localparam int CLS_STORE     = 3;
    localparam int CLS_BRANCH    = 4;
    localparam int CLS_IMM_JUMP  = 5;
    localparam int CLS_REG_JUMP  = 6;
    localparam int CLS_LUI       = 7;
    localparam int CLS_AUIPC     = 8;
    localparam int CLS_ENV       = 9;
    localparam int NUM_CLASSES   = 10;

    // Records carry the widest supported PC; narrower PCs are zero-extended.
    localparam int PC_MAX_WIDTH = 64;

    typedef struct packed {
        logic [PC_MAX_WIDTH-1:0] pc;
        logic [NUM_CLASSES-1:0]  cls;
        logic                    legal;
        logic [31:0]             imm;
        logic                    imm_valid;
        logic [4:0]              rs1;
        logic                    rs1_valid;
        logic [4:0]              rs2;
        logic                    rs2_valid;
        logic [4:0]              rd;
        logic                    rd_valid;
        logic [2:0]              funct3;
        logic                    funct3_valid;
        logic [6:0]              funct7;
        logic                    funct7_valid;
    } decoded_instr_t;

    // Format chosen from the opcode; anything not S/B/J/U uses the I layout.
    function automatic logic [31:0] immediate_of(input logic [31:0] i);
        logic [31:0] r;
        case (i[6:0])
            OPC_STORE:
                r = {{20{i[31]}}, i[31:25], i[11:7]};
            OPC_BRANCH:
                r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OPC_JAL:
                r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            OPC_LUI, OPC_AUIPC:
                r = {i[31:12], 12'b0};
            default:
                r = {{20{i[31]}}, i[31:20]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_queue_decoder.sv
// Combinational RV32I decoder: raw word + PC in, decoded_instr_t out.
// Ports: instruction_data, instruction_data_valid, pc -> decoded (all flags 0 when invalid).
module decode_queue_decoder
    import decode_pkg::*;
(
    input  logic [31:0]             instruction_data,
    input  logic                    instruction_data_valid,
    input  logic [PC_MAX_WIDTH-1:0] pc,
    output decoded_instr_t          decoded
);

    logic [6:0]             opc;
    logic [NUM_CLASSES-1:0] cls;
    decoded_instr_t         d;

    assign opc = instruction_data[6:0];

    always_comb begin
        cls = '0;
        if (instruction_data_valid) begin
            cls[CLS_REG_ARITH] = (opc == OPC_OP);
            cls[CLS_IMM_ARITH] = (opc == OPC_OP_IMM);
            cls[CLS_LOAD]      = (opc == OPC_LOAD);
            cls[CLS_STORE]     = (opc == OPC_STORE);
            cls[CLS_BRANCH]    = (opc == OPC_BRANCH);
            cls[CLS_IMM_JUMP]  = (opc == OPC_JAL);
            cls[CLS_REG_JUMP]  = (opc == OPC_JALR);
            cls[CLS_LUI]       = (opc == OPC_LUI);
            cls[CLS_AUIPC]     = (opc == OPC_AUIPC);
            cls[CLS_ENV]       = (opc == OPC_SYSTEM);
        end
    end

    always_comb begin
        d        = '0;
        d.pc     = pc;
        d.cls    = cls;
        d.legal  = |cls;
        d.rd     = instruction_data[11:7];
        d.funct3 = instruction_data[14:12];
        d.rs1    = instruction_data[19:15];
        d.rs2    = instruction_data[24:20];
        d.funct7 = instruction_data[31:25];
        unique case (1'b1)
            cls[CLS_REG_ARITH]: begin
                d.rs1_valid    = 1'b1;
                d.rs2_valid    = 1'b1;
                d.rd_valid     = 1'b1;
                d.funct3_valid = 1'b1;
                d.funct7_valid = 1'b1;
            end
            cls[CLS_IMM_ARITH]: begin
                d.imm_valid    = 1'b1;
                d.rs1_valid    = 1'b1;
                d.rd_valid     = 1'b1;
                d.funct3_valid = 1'b1;
                // Only shifts use the funct7 slot.
                d.funct7_valid = (d.funct3 == 3'b001) ||
                                 (d.funct3 == 3'b101);
            end
            cls[CLS_LOAD], cls[CLS_REG_JUMP]: begin
                d.imm_valid    = 1'b1;
                d.rs1_valid    = 1'b1;
                d.rd_valid     = 1'b1;
                d.funct3_valid = 1'b1;
            end
            cls[CLS_STORE], cls[CLS_BRANCH]: begin
                d.imm_valid    = 1'b1;
                d.rs1_valid    = 1'b1;
                d.rs2_valid    = 1'b1;
                d.funct3_valid = 1'b1;
            end
            cls[CLS_IMM_JUMP], cls[CLS_LUI], cls[CLS_AUIPC]: begin
                d.imm_valid = 1'b1;
                d.rd_valid  = 1'b1;
            end
            cls[CLS_ENV]: begin
                d.imm_valid    = 1'b1;
                d.funct3_valid = 1'b1;
            end
            default: ;
        endcase
        d.imm = d.imm_valid ? immediate_of(instruction_data) : '0;
    end

    assign decoded = d;

endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: decodes fetch words and queues records for execute.
// Ports: clk, rst (async low), in_* handshake, flush, out_* decoded head, count.
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_instruction,
    input  logic [PC_WIDTH-1:0]         in_pc,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PC_WIDTH-1:0]         out_pc,
    output logic [9:0]                  out_class,
    output logic                        out_opcode_legal,
    output logic [31:0]                 out_immediate,
    output logic                        out_immediate_valid,
    output logic [4:0]                  out_register_1,
    output logic [4:0]                  out_register_2,
    output logic [4:0]                  out_write_register,
    output logic                        out_register_1_valid,
    output logic                        out_register_2_valid,
    output logic                        out_write_register_valid,
    output logic [2:0]                  out_funct_3,
    output logic                        out_funct_3_valid,
    output logic [6:0]                  out_funct_7,
    output logic                        out_funct_7_valid,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [CW-1:0]           cnt;
    logic [PC_MAX_WIDTH-1:0] in_pc_ext;
    decoded_instr_t          dec;
    decoded_instr_t          head_raw;
    decoded_instr_t          head;
    logic                    push;
    logic                    pop;
    logic                    unused_pc;

    assign in_pc_ext = PC_MAX_WIDTH'(in_pc);

    decode_queue_decoder u_decoder (
        .instruction_data       (in_instruction),
        .instruction_data_valid (in_valid),
        .pc                     (in_pc_ext),
        .decoded                (dec)
    );

    // Depends only on occupancy and flush, never on out_ready.
    assign in_ready  = (cnt < CW'(DEPTH)) && !flush;
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (push && !pop) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !push) begin
            cnt <= cnt - CW'(1);
        end
    end

    generate
        if (DEPTH == 1) begin : g_single
            decoded_instr_t slot;

            always_ff @(posedge clk) begin
                if (push) begin
                    slot <= dec;
                end
            end

            assign head_raw = slot;
        end else begin : g_ring
            localparam int PW = $clog2(DEPTH);

            logic [PW-1:0]  wptr;
            logic [PW-1:0]  rptr;
            decoded_instr_t mem [DEPTH];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wptr <= '0;
                    rptr <= '0;
                end else if (flush) begin
                    wptr <= '0;
                    rptr <= '0;
                end else begin
                    if (push) wptr <= wptr + PW'(1);
                    if (pop)  rptr <= rptr + PW'(1);
                end
            end

            // Payload needs no reset: it is masked until out_valid.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wptr] <= dec;
                end
            end

            assign head_raw = mem[rptr];
        end
    endgenerate

    assign head = out_valid ? head_raw : '0;

    assign count                    = cnt;
    assign out_pc                   = head.pc[PC_WIDTH-1:0];
    assign out_class                = head.cls;
    assign out_opcode_legal         = head.legal;
    assign out_immediate            = head.imm;
    assign out_immediate_valid      = head.imm_valid;
    assign out_register_1           = head.rs1;
    assign out_register_2           = head.rs2;
    assign out_write_register       = head.rd;
    assign out_register_1_valid     = head.rs1_valid;
    assign out_register_2_valid     = head.rs2_valid;
    assign out_write_register_valid = head.rd_valid;
    assign out_funct_3              = head.funct3;
    assign out_funct_3_valid        = head.funct3_valid;
    assign out_funct_7              = head.funct7;
    assign out_funct_7_valid        = head.funct7_valid;

    assign unused_pc = ^head.pc;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=2, PC_WIDTH=32).
// One task per scenario; expected values hand-decoded from RV32I encodings.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [9:0]  out_class;
    logic        out_opcode_legal;
    logic [31:0] out_immediate;
    logic        out_immediate_valid;
    logic [4:0]  out_register_1;
    logic [4:0]  out_register_2;
    logic [4:0]  out_write_register;
    logic        out_register_1_valid;
    logic        out_register_2_valid;
    logic        out_write_register_valid;
    logic [2:0]  out_funct_3;
    logic        out_funct_3_valid;
    logic [6:0]  out_funct_7;
    logic        out_funct_7_valid;
    logic [1:0]  count;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(2), .PC_WIDTH(32)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .in_instruction           (in_instruction),
        .in_pc                    (in_pc),
        .flush                    (flush),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .out_pc                   (out_pc),
        .out_class                (out_class),
        .out_opcode_legal         (out_opcode_legal),
        .out_immediate            (out_immediate),
        .out_immediate_valid      (out_immediate_valid),
        .out_register_1           (out_register_1),
        .out_register_2           (out_register_2),
        .out_write_register       (out_write_register),
        .out_register_1_valid     (out_register_1_valid),
        .out_register_2_valid     (out_register_2_valid),
        .out_write_register_valid (out_write_register_valid),
        .out_funct_3              (out_funct_3),
        .out_funct_3_valid        (out_funct_3_valid),
        .out_funct_7              (out_funct_7),
        .out_funct_7_valid        (out_funct_7_valid),
        .count                    (count)
    );

    localparam logic [31:0] ADDI = 32'h01700793;
    localparam logic [31:0] SW   = 32'h00512423;
    localparam logic [31:0] BEQ  = 32'hfe000ee3;
    localparam logic [31:0] LUI  = 32'h123450b7;
    localparam logic [31:0] BAD  = 32'hffffffff;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
        in_valid       = v;
        in_instruction = i;
        in_pc          = p;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #2;
        compared++;
        if (count !== 2'd0) begin mismatched++;
            $display("FAIL reset count: got %0d want 0", count); end
        compared++;
        if (out_valid !== 1'b0) begin mismatched++;
            $display("FAIL reset out_valid: got %b want 0", out_valid); end
        compared++;
        if ({out_class, out_opcode_legal, out_immediate, out_pc} !== 75'd0) begin mismatched++;
            $display("FAIL reset head: class %h legal %b imm %h pc %h want all 0",
                     out_class, out_opcode_legal, out_immediate, out_pc); end
        #10;
        rst = 1'b1;
        step();
        compared++;
        if (in_ready !== 1'b1) begin mismatched++;
            $display("FAIL reset in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_push();
        out_ready = 1'b1;
        drive(1'b1, ADDI, 32'h100);
        step();
        drive(1'b0, 32'h0, 32'h0);
        compared++;
        if (out_valid !== 1'b1) begin mismatched++;
            $display("FAIL addi out_valid: got %b want 1", out_valid); end
        compared++;
        if (out_class !== 10'h002) begin mismatched++;
            $display("FAIL addi class: got %h want 002", out_class); end
        compared++;
        if (out_immediate !== 32'h17) begin mismatched++;
            $display("FAIL addi imm: got %h want 17", out_immediate); end
        compared++;
        if ({out_register_1, out_write_register} !== {5'd0, 5'd15}) begin mismatched++;
            $display("FAIL addi regs: got rs1 %0d rd %0d want 0 15",
                     out_register_1, out_write_register); end
        compared++;
        if ({out_register_1_valid, out_register_2_valid, out_write_register_valid,
             out_opcode_legal, out_immediate_valid, out_funct_3_valid, out_funct_7_valid}
            !== 7'b1011110) begin mismatched++;
            $display("FAIL addi flags: got %b%b%b%b%b%b%b want 1011110",
                     out_register_1_valid, out_register_2_valid, out_write_register_valid,
                     out_opcode_legal, out_immediate_valid, out_funct_3_valid,
                     out_funct_7_valid); end
        compared++;
        if (out_pc !== 32'h100) begin mismatched++;
            $display("FAIL addi pc: got %h want 100", out_pc); end
        step();
        compared++;
        if ({out_valid, count, out_class} !== 13'd0) begin mismatched++;
            $display("FAIL addi drained: valid %b count %0d class %h want 0 0 0",
                     out_valid, count, out_class); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, SW, 32'h200);
        step();
        drive(1'b1, BEQ, 32'h204);
        step();
        drive(1'b0, 32'h0, 32'h0);
        compared++;
        if ({count, in_ready} !== {2'd2, 1'b0}) begin mismatched++;
            $display("FAIL full state: count %0d in_ready %b want 2 0", count, in_ready); end
        step();
        compared++;
        if ({out_class, out_immediate} !== {10'h008, 32'h8}) begin mismatched++;
            $display("FAIL sw head: class %h imm %h want 008 8", out_class, out_immediate); end
        compared++;
        if ({out_register_1, out_register_2, out_write_register_valid, out_pc}
            !== {5'd2, 5'd5, 1'b0, 32'h200}) begin mismatched++;
            $display("FAIL sw fields: rs1 %0d rs2 %0d rdv %b pc %h want 2 5 0 200",
                     out_register_1, out_register_2, out_write_register_valid, out_pc); end
        out_ready = 1'b1;
        step();
        compared++;
        if ({out_class, out_immediate, count} !== {10'h010, 32'hfffffffc, 2'd1}) begin
            mismatched++;
            $display("FAIL beq head: class %h imm %h count %0d want 010 fffffffc 1",
                     out_class, out_immediate, count); end
        step();
        compared++;
        if (count !== 2'd0) begin mismatched++;
            $display("FAIL beq drained: count %0d want 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        drive(1'b1, ADDI, 32'h300);
        step();
        drive(1'b1, SW, 32'h304);
        step();
        drive(1'b1, LUI, 32'h308);
        out_ready = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b0) begin mismatched++;
            $display("FAIL full in_ready with pop: got %b want 0", in_ready); end
        step();
        drive(1'b0, 32'h0, 32'h0);
        compared++;
        if ({count, out_pc, out_class} !== {2'd1, 32'h304, 10'h008}) begin mismatched++;
            $display("FAIL full pop: count %0d pc %h class %h want 1 304 008",
                     count, out_pc, out_class); end
        step();
        compared++;
        if ({count, out_valid} !== 3'd0) begin mismatched++;
            $display("FAIL full refused push: count %0d valid %b want 0 0", count, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        drive(1'b1, ADDI, 32'h400);
        step();
        drive(1'b1, SW, 32'h404);
        step();
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, LUI, 32'h408);
        #1;
        compared++;
        if (in_ready !== 1'b0) begin mismatched++;
            $display("FAIL flush in_ready: got %b want 0", in_ready); end
        step();
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        compared++;
        if ({count, out_valid} !== 3'd0) begin mismatched++;
            $display("FAIL flush empty: count %0d valid %b want 0 0", count, out_valid); end
        step();
        compared++;
        if (count !== 2'd0) begin mismatched++;
            $display("FAIL flush lui dropped: count %0d want 0", count); end
        drive(1'b1, LUI, 32'h40c);
        step();
        drive(1'b0, 32'h0, 32'h0);
        compared++;
        if ({out_immediate, out_class, out_write_register, out_pc}
            !== {32'h12345000, 10'h080, 5'd1, 32'h40c}) begin mismatched++;
            $display("FAIL lui repush: imm %h class %h rd %0d pc %h want 12345000 080 1 40c",
                     out_immediate, out_class, out_write_register, out_pc); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        drive(1'b1, BAD, 32'h500);
        step();
        drive(1'b0, 32'h0, 32'h0);
        compared++;
        if ({out_valid, out_opcode_legal, out_class} !== {1'b1, 1'b0, 10'h000}) begin
            mismatched++;
            $display("FAIL illegal head: valid %b legal %b class %h want 1 0 000",
                     out_valid, out_opcode_legal, out_class); end
        compared++;
        if ({out_immediate_valid, out_register_1_valid, out_register_2_valid,
             out_write_register_valid, out_funct_3_valid, out_funct_7_valid} !== 6'd0) begin
            mismatched++;
            $display("FAIL illegal flags: got %b%b%b%b%b%b want 000000",
                     out_immediate_valid, out_register_1_valid, out_register_2_valid,
                     out_write_register_valid, out_funct_3_valid, out_funct_7_valid); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(1'b1, ADDI, 32'h600);
        step();
        for (int k = 1; k < 4; k++) begin
            compared++;
            if ({count, out_pc} !== {2'd1, 32'h600 + 32'(4 * (k - 1))}) begin mismatched++;
                $display("FAIL stream %0d: count %0d pc %h want 1 %h",
                         k, count, out_pc, 32'h600 + 32'(4 * (k - 1))); end
            drive(1'b1, ADDI, 32'h600 + 32'(4 * k));
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        drive(1'b1, ADDI, 32'h700);
        step();
        drive(1'b1, SW, 32'h704);
        step();
        drive(1'b0, 32'h0, 32'h0);
        compared++;
        if (count !== 2'd2) begin mismatched++;
            $display("FAIL pre-reset count: got %0d want 2", count); end
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if ({count, out_valid, out_class} !== 13'd0) begin mismatched++;
            $display("FAIL async reset: count %0d valid %b class %h want 0 0 000",
                     count, out_valid, out_class); end
        #3;
        rst = 1'b1;
        step();
        compared++;
        if ({count, in_ready} !== {2'd0, 1'b1}) begin mismatched++;
            $display("FAIL post-reset: count %0d in_ready %b want 0 1", count, in_ready); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_backpressure();
        test_full_push_pop();
        test_flush();
        test_illegal();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
